// File: rtl/boot_uart_loader.sv
// Boot loader: polls a UART over its register bus, packs received bytes into
// little-endian 32-bit words, writes them to IMEM, then sends one ack byte.
module boot_uart_loader #(
  parameter int         NUM_WORDS = 1024,
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] ACK_BYTE  = 8'h06
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  inout  wire  [7:0]        databus,
  output logic              iocs,
  output logic              iorw,
  output logic [1:0]        ioaddr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_POLL_RX = 3'd1;
  localparam logic [2:0] S_READ    = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_POLL_TX = 3'd4;
  localparam logic [2:0] S_SEND    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        bytecnt_q, bytecnt_d;
  logic [ADDR_W-1:0] wordcnt_q, wordcnt_d;
  logic [31:0]       word_q, word_d;

  // Each byte lane loads only on the READ cycle that targets it.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word_d[8*gi +: 8] = (state_q == S_READ && bytecnt_q == 2'(gi))
                                 ? databus : word_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    bytecnt_d = bytecnt_q;
    wordcnt_d = wordcnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_POLL_RX;
          bytecnt_d = 2'd0;
          wordcnt_d = '0;
        end
      end
      S_POLL_RX: begin
        if (databus[0]) state_d = S_READ;
      end
      S_READ: begin
        bytecnt_d = bytecnt_q + 2'd1;
        state_d   = (bytecnt_q == 2'd3) ? S_WRITE : S_POLL_RX;
      end
      S_WRITE: begin
        // The counter stops at the last word so mem_addr never wraps.
        if (wordcnt_q == LAST_WORD) begin
          state_d = S_POLL_TX;
        end else begin
          wordcnt_d = wordcnt_q + ADDR_W'(1);
          state_d   = S_POLL_RX;
        end
      end
      S_POLL_TX: begin
        if (databus[1]) state_d = S_SEND;
      end
      S_SEND:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bytecnt_q <= 2'd0;
      wordcnt_q <= '0;
      word_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      bytecnt_q <= bytecnt_d;
      wordcnt_q <= wordcnt_d;
      word_q    <= word_d;
    end
  end

  always_comb begin
    iocs   = (state_q == S_POLL_RX) || (state_q == S_READ) ||
             (state_q == S_POLL_TX) || (state_q == S_SEND);
    iorw   = (state_q != S_SEND);
    ioaddr = ((state_q == S_POLL_RX) || (state_q == S_POLL_TX)) ? 2'b01 : 2'b00;
    mem_we = (state_q == S_WRITE);
    busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    done   = (state_q == S_DONE);
  end

  assign mem_addr  = wordcnt_q;
  assign mem_wdata = word_q;

  // Bus is driven only for the single ack write; the UART owns it otherwise.
  assign databus = (state_q == S_SEND) ? ACK_BYTE : 8'hzz;

endmodule
